// File: rtl/soc_system_cmdsend_pkg.sv
// Shared register map and STATUS/CONTROL bit layout for the HPS-to-FPGA command PIO.
package soc_system_cmdsend_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_ISSUED  = 2'd3;

    localparam int unsigned COUNT_LSB = 0;
    localparam int unsigned EMPTY_BIT = 5;
    localparam int unsigned FULL_BIT  = 6;
    localparam int unsigned OVF_BIT   = 7;
    localparam int unsigned VALID_BIT = 8;

    localparam int unsigned FLUSH_BIT = 0;
    localparam int unsigned ISSUED_W  = 16;

endpackage

// File: rtl/soc_system_cmd_fifo.sv
// Register-array command FIFO; push is refused when full, flush overrides push and pop.
module soc_system_cmd_fifo
    import soc_system_cmdsend_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    wptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset; cmd_valid qualifies any stale head word.
    always_ff @(posedge clk) begin
        if (reset_n && do_push && !flush) mem[wptr] <= din;
    end

endmodule

// File: rtl/soc_system_pio_cmdsend.sv
// Avalon-MM slave pushing HPS command words into a FIFO drained over a valid/ready stream.
module soc_system_pio_cmdsend
    import soc_system_cmdsend_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] cmd_data,
    output logic             cmd_valid,
    input  logic             cmd_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                wr;
    logic                push;
    logic                pop;
    logic                flush;
    logic [CW-1:0]       count;
    logic                empty;
    logic                full;
    logic                overflow;
    logic [ISSUED_W-1:0] issued;
    logic [31:0]         rd_mux;

    assign wr        = chipselect && !write_n;
    assign push      = wr && (address == ADDR_DATA);
    assign flush     = wr && (address == ADDR_CONTROL) && writedata[FLUSH_BIT];
    assign cmd_valid = !empty;
    // A flush in the same cycle swallows the handshake, so it is neither popped nor counted.
    assign pop       = cmd_valid && cmd_ready && !flush;

    soc_system_cmd_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .din    (writedata[WIDTH-1:0]),
        .dout   (cmd_data),
        .count  (count),
        .empty  (empty),
        .full   (full)
    );

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: begin
                if (!empty) rd_mux[WIDTH-1:0] = cmd_data;
            end
            ADDR_STATUS: begin
                rd_mux[COUNT_LSB +: CW] = count;
                rd_mux[EMPTY_BIT]       = empty;
                rd_mux[FULL_BIT]        = full;
                rd_mux[OVF_BIT]         = overflow;
                rd_mux[VALID_BIT]       = cmd_valid;
            end
            ADDR_ISSUED: begin
                rd_mux[ISSUED_W-1:0] = issued;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata <= '0;
            overflow <= 1'b0;
            issued   <= '0;
        end else begin
            readdata <= rd_mux;
            if (push && full)
                overflow <= 1'b1;
            else if (wr && (address == ADDR_STATUS) && writedata[OVF_BIT])
                overflow <= 1'b0;
            if (wr && (address == ADDR_ISSUED))
                issued <= '0;
            else if (pop)
                issued <= issued + ISSUED_W'(1);
        end
    end

endmodule
